seg_display_mux: RTL
====================

# seg_display_mux

Multiplexed multi-digit seven-segment display driver for the FPGA CPU top level. It is the parametrised successor to the single-digit hex decoder. It captures a packed hex word from the datapath output and scans it across `DIGITS` common-anode/cathode digits with a prescaled time base. Updates are tear-free, taking effect only at frame boundaries, and each digit can be blanked individually.

## Interface
- `DIGITS`, default 4: number of digits scanned; legal range 1–8.
- `SCAN_DIV`, default 50000: clock cycles each digit is lit; minimum 2.
- `ACTIVE_LOW`, default 1: when 1, `seg`, `dp` and `an` are active-low (lit = 0); when 0, active-high.
- `clk` input 1: system clock; all state on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `data_in` input 4*DIGITS: packed nibbles; nibble k (bits 4k+3:4k) drives digit k, where digit 0 is least significant.
- `load` input 1: capture strobe for `data_in`, `dp_in`, `blank_mask`.
- `dp_in` input DIGITS: decimal-point request per digit.
- `blank_mask` input DIGITS: 1 forces that digit dark.
- `seg` output 7: segment drive in {g,f,e,d,c,b,a} order.
- `dp` output 1: decimal-point drive for the lit digit.
- `an` output DIGITS: one-hot digit enable.
- `frame_done` output 1: one-cycle pulse when a new frame starts.

## Operation
- Prescaler `pcnt` counts 0..SCAN_DIV-1, then wraps. Digit index `idx` advances when `pcnt` == SCAN_DIV-1, and wraps from DIGITS-1 to 0 (a "frame wrap").
- Shadow register set: `sh_data`, `sh_dp`, `sh_blank`, plus a `pending` flag.
  - `load`=1 captures the inputs into the shadow set and sets `pending`.
  - A later `load` before the wrap overwrites the shadow set; the last one wins.
- Display register set: `dsp_data`, `dsp_dp`, `dsp_blank`.
  - Updated only on the frame-wrap cycle, and only if `pending`=1. `pending` is then cleared.
  - If `load`=1 on the frame-wrap cycle, the display set takes the inputs directly and `pending` ends cleared.
- Hex encoding (active-high gfedcba): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1100111, A=1110111, B=1111100, C=1011000, D=1011110, E=1111001, F=1110001.
- For the lit digit `idx`:
  - `an` bit `idx` is active and all other bits are inactive.
  - `seg` = encode(dsp_data nibble `idx`), or all-off if `dsp_blank[idx]`.
  - `dp` = `dsp_dp[idx]` and not blanked.
- `ACTIVE_LOW` inverts `seg`, `dp` and `an` at the output registers only.

## Timing
- Reset asserted (asynchronous), all state cleared:
  - `pcnt`, `idx`, `pending`, shadow set and display set all 0.
  - `seg`, `dp`, `an` all inactive (all ones when ACTIVE_LOW=1).
  - `frame_done`=0.
- Reset is honoured mid-frame and mid-load. A `load` in the cycle reset releases is accepted normally.
- `seg`/`dp`/`an` are registered. They reflect `idx` and the display set with 1-cycle latency.
  - First edge after reset release: outputs show digit 0 with value 0, i.e. `an`=...1110 and `seg`=1000000 when ACTIVE_LOW=1, DIGITS=4.
- Each digit is lit for exactly SCAN_DIV cycles; a frame is DIGITS*SCAN_DIV cycles.
  - DIGITS=1: `an` is constant active, and every prescaler wrap is a frame wrap.
- `frame_done` is registered. It pulses high the cycle after the frame-wrap edge, the same cycle new display data first appears on `seg`.
- Load-to-display latency ranges from 2 cycles (load on the wrap cycle) to DIGITS*SCAN_DIV+1 cycles.
- No glitch requirement beyond registered outputs. `an` never has two active bits in any cycle.

## Configuration
- `SEG_LEADING_ZERO_BLANK_EN` defined:
  - Digits above the most significant non-zero nibble of `dsp_data` are additionally blanked, ORed with `dsp_blank`. Their `dp` is still shown.
  - Digit 0 is never auto-blanked, so value 0 shows a single "0".
  - The blank vector is computed combinationally from the display set; latency is unchanged.
- Undefined: all digits display their nibble unless `blank_mask` blanks them. No extra logic is synthesised.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1.
- Reset: hold `reset`=0 for 3 cycles mid-scan -> `seg`=1111111, `an`=1111, `dp`=1, `frame_done`=0. After release, `an` shows 1110→1101→1011→0111, each for 4 cycles, repeating every 16 cycles.
- Full hex sweep: load 0x0123 then 0x4567, 0x89AB, 0xCDEF on successive frames -> each digit's `seg` equals the ~pattern above for every nibble 0–F.
- Tear-free: load 0x1234 at cycle 5 of a frame -> digits keep the old value until the wrap. `frame_done` pulses once, then 4,3,2,1 appear on digits 0..3.
- Load on the wrap cycle with a pending older load 0xAAAA: new 0x5555 on the wrap cycle -> display shows 0x5555 next frame and `pending`=0; the following frame is unchanged.
- Blank/dp: `blank_mask`=0100, `dp_in`=0001, data 0x8888 -> digit 2 has `seg`=1111111 and `dp`=1; digit 0 has `dp`=0.
- With `SEG_LEADING_ZERO_BLANK_EN`: data 0x0040 -> digits 3,2 dark, digit 1 shows 4, digit 0 shows 0. Data 0x0000 -> only digit 0 shows "0".

Source files
------------

// File: rtl/seg_display_if.sv
// Bundle of the capture inputs and scan outputs of the seven-segment display driver.
// The datapath side uses master; the driver uses slave.
interface seg_display_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] data_in;
  logic                load;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blank_mask;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;
  logic                frame_done;

  modport master (
    output data_in, load, dp_in, blank_mask,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  data_in, load, dp_in, blank_mask,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg_display_mux.sv
// Multiplexed DIGITS-wide seven-segment scanner with frame-synchronous, tear-free updates.
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to darken leading zero digits.
module seg_display_mux #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  seg_display_if.slave bus
);

  localparam int PC_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  function automatic logic [6:0] hex_encode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1100111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b1011000;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] pol_seg(input logic [6:0] v);
    return ACTIVE_LOW ? ~v : v;
  endfunction

  function automatic logic pol_bit(input logic v);
    return ACTIVE_LOW ? ~v : v;
  endfunction

  function automatic logic [DIGITS-1:0] pol_an(input logic [DIGITS-1:0] v);
    return ACTIVE_LOW ? ~v : v;
  endfunction

  logic [PC_W-1:0]     pcnt;
  logic [IDX_W-1:0]    idx;
  logic                pending;
  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_blank;
  logic [4*DIGITS-1:0] dsp_data;
  logic [DIGITS-1:0]   dsp_dp;
  logic [DIGITS-1:0]   dsp_blank;
  logic                wrap_p0;

  logic [6:0]          seg_p1;
  logic                dp_p1;
  logic [DIGITS-1:0]   an_p1;
  logic                frame_done_p1;

  logic                pcnt_wrap;
  logic                frame_wrap;
  logic [DIGITS-1:0]   seg_blank;
  logic [DIGITS-1:0]   an_raw;
  logic [3:0]          nib_sel;
  logic                dp_sel;
  logic                blank_sel;
  logic                seg_blank_sel;
  logic [6:0]          seg_nxt;
  logic                dp_nxt;

  assign pcnt_wrap  = (pcnt == PC_LAST);
  assign frame_wrap = pcnt_wrap && (idx == IDX_LAST);

  // Stage p0: prescaler, digit index and the shadow/display register sets
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (pcnt_wrap) begin
      pcnt <= '0;
      idx  <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      pcnt <= pcnt + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_data  <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
    end else if (bus.load) begin
      sh_data  <= bus.data_in;
      sh_dp    <= bus.dp_in;
      sh_blank <= bus.blank_mask;
    end
  end

  // A load on the wrap cycle bypasses the shadow set and leaves nothing pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending   <= 1'b0;
      dsp_data  <= '0;
      dsp_dp    <= '0;
      dsp_blank <= '0;
    end else if (frame_wrap) begin
      pending <= 1'b0;
      if (bus.load) begin
        dsp_data  <= bus.data_in;
        dsp_dp    <= bus.dp_in;
        dsp_blank <= bus.blank_mask;
      end else if (pending) begin
        dsp_data  <= sh_data;
        dsp_dp    <= sh_dp;
        dsp_blank <= sh_blank;
      end
    end else if (bus.load) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap_p0 <= 1'b0;
    end else begin
      wrap_p0 <= frame_wrap;
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz_mask;
  logic              zero_above;

  // Digit 0 is excluded so an all-zero value still shows a single "0".
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & (dsp_data[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_above;
    end
  end

  assign seg_blank = dsp_blank | lz_mask;
`else
  assign seg_blank = dsp_blank;
`endif

  always_comb begin
    nib_sel       = 4'h0;
    dp_sel        = 1'b0;
    blank_sel     = 1'b0;
    seg_blank_sel = 1'b0;
    an_raw        = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        nib_sel       = dsp_data[4*k +: 4];
        dp_sel        = dsp_dp[k];
        blank_sel     = dsp_blank[k];
        seg_blank_sel = seg_blank[k];
        an_raw[k]     = 1'b1;
      end
    end
  end

  assign seg_nxt = seg_blank_sel ? 7'h00 : hex_encode(nib_sel);
  assign dp_nxt  = dp_sel & ~blank_sel;

  // Stage p1: registered pad drive, polarity applied here only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_p1        <= pol_seg(7'h00);
      dp_p1         <= pol_bit(1'b0);
      an_p1         <= pol_an('0);
      frame_done_p1 <= 1'b0;
    end else begin
      seg_p1        <= pol_seg(seg_nxt);
      dp_p1         <= pol_bit(dp_nxt);
      an_p1         <= pol_an(an_raw);
      frame_done_p1 <= wrap_p0;
    end
  end

  assign bus.seg        = seg_p1;
  assign bus.dp         = dp_p1;
  assign bus.an         = an_p1;
  assign bus.frame_done = frame_done_p1;

endmodule
